// File: rtl/uart_rx_ms.sv
// Oversampling UART receiver with majority-vote bit sampling, configurable
// framing (parity, one or two stop bits), break detection and a
// first-word-fall-through receive FIFO with a sticky overflow flag.
module uart_rx_ms #(
    parameter int DATA_BITS  = 8,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    input  logic                          rx_in,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_par_err,
    output logic                          rx_frm_err,
    output logic                          rx_brk,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 3;

    localparam logic [SW-1:0] S_MID_LO = SW'(OVS/2 - 1);
    localparam logic [SW-1:0] S_MID    = SW'(OVS/2);
    localparam logic [SW-1:0] S_MID_HI = SW'(OVS/2 + 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVS - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_BRKWAIT
    } state_t;

    logic                 r_sync1, r_sync2;
    logic                 w_rxs;
    logic [DIV_W-1:0]     r_tick_cnt;
    logic [DIV_W-1:0]     w_div_m1;
    logic                 w_tick;
    state_t               r_state, w_next;
    logic [SW-1:0]        r_samp_cnt;
    logic                 r_s0, r_s1;
    logic                 w_maj, w_mid_hi, w_bit_end, w_start;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit, r_stop1;
    logic                 r_cfg_par_en, r_cfg_odd, r_cfg_two;
    logic                 w_stop1_val, w_brk, w_frm, w_par, w_push;
    logic [EW-1:0]        w_entry;

    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_level;
    logic                 r_overflow;
    logic                 w_full, w_pop, w_wr, w_drop;
    logic [EW-1:0]        w_head;

    assign w_rxs     = r_sync2;
    assign w_div_m1  = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    assign w_tick    = (r_tick_cnt == w_div_m1);
    assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_mid_hi  = w_tick && (r_samp_cnt == S_MID_HI);
    assign w_bit_end = w_tick && (r_samp_cnt == S_LAST);
    assign w_start   = (r_state == ST_IDLE) && !w_rxs;

    // Frame status as seen at the mid-sample of the last stop bit.
    assign w_stop1_val = (r_state == ST_STOP1) ? w_maj : r_stop1;
    assign w_brk   = (r_shift == '0) && (!r_cfg_par_en || !r_par_bit) && !w_stop1_val;
    assign w_frm   = !w_stop1_val || ((r_state == ST_STOP2) && !w_maj) || w_brk;
    assign w_par   = r_cfg_par_en && ((^r_shift) ^ r_par_bit ^ r_cfg_odd);
    assign w_entry = {w_brk, w_frm, w_par, r_shift};

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // Oversample tick generator, realigned to the falling edge of a start bit.
    always_ff @(posedge clk) begin
        if (!reset || w_start || w_tick) r_tick_cnt <= '0;
        else                             r_tick_cnt <= r_tick_cnt + DIV_W'(1);
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and push request.
    // NOTE: defaults come first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        case (r_state)
            ST_IDLE:    if (!w_rxs) w_next = ST_START;
            ST_START: begin
                if (w_mid_hi && w_maj) w_next = ST_IDLE;
                else if (w_bit_end)    w_next = ST_DATA;
            end
            ST_DATA:
                if (w_bit_end && (r_bit_cnt == B_LAST))
                    w_next = r_cfg_par_en ? ST_PARITY : ST_STOP1;
            ST_PARITY:  if (w_bit_end) w_next = ST_STOP1;
            ST_STOP1: begin
                if (w_mid_hi && !r_cfg_two) begin
                    w_push = 1'b1;
                    w_next = w_brk ? ST_BRKWAIT : ST_IDLE;
                end else if (w_bit_end) begin
                    w_next = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (w_mid_hi) begin
                    w_push = 1'b1;
                    w_next = w_brk ? ST_BRKWAIT : ST_IDLE;
                end
            end
            ST_BRKWAIT: if (w_rxs) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Bit sampling, majority capture, data shift and frame config latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_samp_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_stop1      <= 1'b0;
            r_cfg_par_en <= 1'b0;
            r_cfg_odd    <= 1'b0;
            r_cfg_two    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            if (!w_rxs) begin
                r_cfg_par_en <= parity_en;
                r_cfg_odd    <= parity_odd;
                r_cfg_two    <= two_stop;
            end
        end else if (w_tick) begin
            r_samp_cnt <= (r_samp_cnt == S_LAST) ? '0 : r_samp_cnt + SW'(1);
            if (r_samp_cnt == S_MID_LO) r_s0 <= w_rxs;
            if (r_samp_cnt == S_MID)    r_s1 <= w_rxs;
            if (r_samp_cnt == S_MID_HI) begin
                case (r_state)
                    ST_DATA:   r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                    ST_PARITY: r_par_bit <= w_maj;
                    ST_STOP1:  r_stop1   <= w_maj;
                    default:   ;
                endcase
            end
            if ((r_samp_cnt == S_LAST) && (r_state == ST_DATA))
                r_bit_cnt <= r_bit_cnt + BW'(1);
        end
    end

    assign w_full = (r_level == FULL_LVL);
    assign w_pop  = rx_valid && rx_ready;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    // FIFO storage; the head is gated to zero whenever the FIFO is empty.
    // NOTE: the storage array has no reset; valid data is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_entry;
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign rx_valid   = (r_level != '0);
    assign rx_data    = rx_valid ? w_head[DATA_BITS-1:0] : '0;
    assign rx_par_err = rx_valid && w_head[DATA_BITS];
    assign rx_frm_err = rx_valid && w_head[DATA_BITS+1];
    assign rx_brk     = rx_valid && w_head[DATA_BITS+2];
    assign level      = r_level;
    assign overflow   = r_overflow;

endmodule

// File: doc/uart_rx_ms.md
UART_RX_MS -- requirements
Module: uart_rx_ms

Interface
Parameters (name, default, meaning):
- REQ-001: DATA_BITS, 8, data bits per frame, legal 5..9.
- REQ-002: OVS, 16, oversample ticks per bit, even, legal 8..32.
- REQ-003: FIFO_DEPTH, 8, receive FIFO entries, power of two, at least 2.
- REQ-004: DIV_W, 12, width of baud_div.

Ports (name, direction, width, meaning):
- REQ-005: clk, in, 1, single clock; every flop on its rising edge.
- REQ-006: reset, in, 1, synchronous, active-low (0 = reset).
- REQ-007: baud_div, in, DIV_W, clk cycles per oversample tick; 0 treated as 1.
- REQ-008: parity_en, in, 1, parity bit present.
- REQ-009: parity_odd, in, 1, 1 = odd parity, 0 = even.
- REQ-010: two_stop, in, 1, two stop bits.
- REQ-011: rx_in, in, 1, asynchronous serial line, idle high.
- REQ-012: rx_data, out, DATA_BITS, FIFO head data.
- REQ-013: rx_par_err / rx_frm_err / rx_brk, out, 1 each, FIFO head flags.
- REQ-014: rx_valid, out, 1, FIFO non-empty.
- REQ-015: rx_ready, in, 1, consumer pop request.
- REQ-016: level, out, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
- REQ-017: overflow, out, 1, sticky: a frame was dropped.
- REQ-018: ovf_clr, in, 1, one-cycle pulse clearing overflow.

Function
- REQ-019: rx_in SHALL pass through a 2-flop synchronizer (reset value 1); all logic uses the synchronized line rxs.
- REQ-020: Tick counter SHALL count 0..baud_div-1 and assert tick for one cycle at baud_div-1; it restarts at 0 on entry to START.
- REQ-021: FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT.
- REQ-022: In IDLE, rxs==0 SHALL move to START and latch parity_en, parity_odd, two_stop; config changes mid-frame SHALL NOT affect the current frame.
- REQ-023: Per-bit sample counter SHALL run 0..OVS-1 on ticks; the bit value is the 2-of-3 majority of samples at counts OVS/2-1, OVS/2, OVS/2+1; the bit ends at count OVS-1.
- REQ-024: In START, majority 1 SHALL be a false start: return to IDLE, no push.
- REQ-025: DATA SHALL shift in DATA_BITS bits LSB first, then go to PARITY if parity_en, else STOP1.
- REQ-026: par_err SHALL be 1 when XOR(data, parity bit, parity_odd) != 0; 0 when parity disabled.
- REQ-027: frm_err SHALL be 1 if any checked stop-bit majority is 0; STOP2 is checked only if two_stop.
- REQ-028: brk SHALL be 1 when all data bits, the parity bit (if present) and stop bit 1 are 0; brk also forces frm_err=1.
- REQ-029: Push SHALL occur at the mid-sample of the last stop bit; FSM then goes to IDLE, or to BRKWAIT if brk; BRKWAIT exits to IDLE when rxs==1.
- REQ-030: FIFO entry SHALL be {brk, frm_err, par_err, data}; the head is presented combinationally (first-word fall-through).
- REQ-031: Pop SHALL occur when rx_valid && rx_ready; pop on empty has no effect.
- REQ-032: Push when full with no pop SHALL drop the frame and set overflow; push and pop in the same cycle when full SHALL both succeed, level unchanged.
- REQ-033: ovf_clr SHALL clear overflow; overflow set in the same cycle as ovf_clr SHALL win.
- REQ-034: Pointers SHALL wrap modulo FIFO_DEPTH; level ranges 0..FIFO_DEPTH.

Reset
- REQ-035: While reset==0 at clk edge: FSM=IDLE, counters=0, synchronizer=1, FIFO empty, level=0, rx_valid=0, overflow=0, rx_data=0, all flags 0.
- REQ-036: Reset mid-frame SHALL discard the partial frame; no push occurs.

Verification (OVS=16, baud_div=4, DATA_BITS=8, FIFO_DEPTH=4)
- V1: 0xA5, even parity, 1 stop -> one entry, rx_data=0xA5, flags 000, level=1.
- V2: 0x3C with wrong even-parity bit 1 -> entry 0x3C, par_err=1, frm_err=0.
- V3: rx_in low for 3 ticks, then high -> no push, FSM back to IDLE, level=0.
- V4: rx_in low 12 bit times, then high -> exactly one entry: data=0x00, brk=1, frm_err=1; the next frame is received normally.
- V5: 5 frames 0x01..0x05, rx_ready=0 -> level=4, overflow=1; pops return 0x01..0x04; ovf_clr clears overflow.
- V6: reset asserted at data bit 3 of 0x55, then 0x66 sent -> only 0x66 is stored.
